// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller that drives an external W-bit ALU through READ/EXEC/WB phases.
// Holds a 4-entry register file, the NZCV status register and the ALU carry-in.
module alu_op_sequencer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic [1:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [1:0]   req_rs1,
  input  logic [1:0]   req_rs2,
  input  logic [1:0]   req_rd,
  input  logic         req_wen,
  input  logic         req_setf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_carry,
  output logic [3:0]   alu_control,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_z,
  input  logic         alu_n,
  output logic         done,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  input  logic [1:0]   rd_addr,
  output logic [W-1:0] rd_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StWb   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [3:0]   op_q;
  logic [1:0]   rs1_q, rs2_q, rd_q;
  logic         wen_q, setf_q;
  logic [W-1:0] alu_a_q, alu_b_q;
  logic [3:0]   alu_control_q;
  logic [W-1:0] out_cap_q;
  logic [3:0]   flags_cap_q;
  logic [W-1:0] result_q;
  logic [3:0]   flags_q;
  logic         done_q;
  logic [W-1:0] rf_q [4];

  // A load in IDLE takes priority over a request in the same cycle.
  assign req_ready = (state_q == StIdle) && !ld_en && !rst;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid && req_ready) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      setf_q        <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= '0;
      out_cap_q     <= '0;
      flags_cap_q   <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      done_q        <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StWb);
      unique case (state_q)
        StIdle: begin
          if (ld_en) begin
            rf_q[ld_addr] <= ld_data;
          end else if (req_valid) begin
            op_q   <= req_op;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            rd_q   <= req_rd;
            wen_q  <= req_wen;
            setf_q <= req_setf;
          end
        end
        StRead: begin
          alu_a_q       <= rf_q[rs1_q];
          alu_b_q       <= rf_q[rs2_q];
          alu_control_q <= op_q;
        end
        StExec: begin
          out_cap_q   <= alu_out;
          flags_cap_q <= {alu_n, alu_z, alu_co, alu_ovf};
        end
        StWb: begin
          result_q <= out_cap_q;
          if (wen_q) rf_q[rd_q] <= out_cap_q;
          if (setf_q) flags_q <= flags_cap_q;
        end
        default: ;
      endcase
    end
  end

  // Carry-in comes from the committed C flag; flags only change at the WB edge.
  assign alu_carry   = flags_q[1];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign done        = done_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign rd_data     = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the alu_* ports plus an array-based
// architectural model (register file + flags) checked after every retired op.
module tb_alu_op_sequencer;

  localparam int W = 8;
  localparam logic [3:0] OpAnd = 4'b0000, OpOr = 4'b0001, OpSub = 4'b0010, OpXor = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100, OpAdc = 4'b0101, OpSbc = 4'b0110;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_en;
  logic [1:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [1:0]   req_rs1, req_rs2, req_rd;
  logic         req_wen, req_setf;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_carry;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_out;
  logic         alu_co, alu_ovf, alu_z, alu_n;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   rd_addr;
  logic [W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Architectural model
  logic [W-1:0] m_rf [4];
  logic [3:0]   m_flags;

  always #10 clk = ~clk;

  alu_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_rd(req_rd), .req_wen(req_wen), .req_setf(req_setf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry), .alu_control(alu_control),
    .alu_out(alu_out), .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_z(alu_z), .alu_n(alu_n),
    .done(done), .result(result), .flags(flags), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Returns {n, z, co, v, out}
  function automatic logic [W+3:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] o;
    logic         co, v;
    s = '0; o = '0; co = 1'b0; v = 1'b0;
    case (op)
      OpAnd: o = a & b;
      OpOr:  o = a | b;
      OpXor: o = a ^ b;
      OpAdd, OpAdc: begin
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == OpAdc) ? cin : 1'b0};
        o  = s[W-1:0];
        co = s[W];
        v  = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]);
      end
      OpSub, OpSbc: begin
        s  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, (op == OpSub) ? 1'b1 : cin};
        o  = s[W-1:0];
        co = s[W];
        v  = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]);
      end
      default: o = '0;
    endcase
    return {o[W-1], (o == '0), co, v, o};
  endfunction

  always_comb {alu_n, alu_z, alu_co, alu_ovf, alu_out} = alu_f(alu_control, alu_a, alu_b,
                                                                alu_carry);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rf();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 chk($sformatf("rf[%0d]", i), 32'(rd_data), 32'(m_rf[i]));
    end
  endtask

  task automatic do_load(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  // Issues one op; optionally holds ld_en high through READ/EXEC to prove it is ignored.
  task automatic run_op(input logic [3:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [1:0] rd, input logic wen, input logic setf,
                        input logic junk_ld);
    logic [W-1:0] a, b;
    logic [W+3:0] r;
    int           cnt;
    @(negedge clk);
    ld_en = 1'b0;
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_wen = wen; req_setf = setf;
    #1 chk("req_ready_accept", 32'(req_ready), 32'd1);
    a = m_rf[rs1];
    b = m_rf[rs2];
    r = alu_f(op, a, b, m_flags[1]);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    ld_en = junk_ld; ld_addr = 2'($urandom_range(0, 3)); ld_data = W'($urandom);
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
      ld_en = junk_ld && (cnt < 3);
    end
    ld_en = 1'b0;
    chk("latency", 32'(cnt), 32'd4);
    if (wen) m_rf[rd] = r[W-1:0];
    if (setf) m_flags = r[W+3:W];
    chk("result", 32'(result), 32'(r[W-1:0]));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_control", 32'(alu_control), 32'(op));
    chk("req_ready_done", 32'(req_ready), 32'd1);
    check_rf();
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_flags = '0;
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; req_valid = 1'b0;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wen = 1'b0; req_setf = 1'b0;
    rd_addr = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk("ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("done_after_rst", 32'(done), 32'd0);
    chk("flags_after_rst", 32'(flags), 32'd0);
    chk("result_after_rst", 32'(result), 32'd0);
    check_rf();

    // 0x7F + 0x01: signed overflow
    do_load(2'd0, 8'h7F);
    do_load(2'd1, 8'h01);
    run_op(OpAdd, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0);
    chk("add_ovf_flags", 32'(flags), 32'b1001);

    // 0xFF + 0x01 sets C, then ADC consumes it
    do_load(2'd0, 8'hFF);
    do_load(2'd3, 8'h00);
    run_op(OpAdd, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0);
    chk("add_carry_flags", 32'(flags), 32'b0110);
    run_op(OpAdc, 2'd3, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    rd_addr = 2'd3;
    #1 chk("adc_r3", 32'(rd_data), 32'h01);
    chk("adc_c_cleared", 32'(flags[1]), 32'd0);

    // Compare-only SUB
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h05);
    do_load(2'd2, 8'hA5);
    run_op(OpSub, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    chk("cmp_z", 32'(flags[2]), 32'd1);

    // Unused op code with setf: result 0, Z set
    run_op(4'b1001, 2'd0, 2'd2, 2'd3, 1'b1, 1'b1, 1'b0);

    // Load and request in the same IDLE cycle: load wins, request taken next cycle
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h22;
    req_valid = 1'b1; req_op = OpAdd; req_rs1 = 2'd1; req_rs2 = 2'd1; req_rd = 2'd0;
    req_wen = 1'b1; req_setf = 1'b0;
    #1 chk("ready_blocked_by_ld", 32'(req_ready), 32'd0);
    m_rf[1] = 8'h22;
    run_op(OpAdd, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    rd_addr = 2'd0;
    #1 chk("ld_then_add", 32'(rd_data), 32'h44);

    // Randomized ops, some with stray loads while busy
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) do_load(2'($urandom_range(0, 3)), W'($urandom));
      run_op(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    // Reset during EXEC aborts the op
    do_load(2'd0, 8'h10);
    do_load(2'd1, 8'h01);
    do_load(2'd2, 8'h55);
    @(negedge clk);
    req_valid = 1'b1; req_op = OpAdd; req_rs1 = 2'd0; req_rs2 = 2'd1; req_rd = 2'd2;
    req_wen = 1'b1; req_setf = 1'b1;
    #1 chk("ready_before_abort", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_alu_b", 32'(alu_b), 32'd0);
    chk("abort_alu_control", 32'(alu_control), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    check_rf();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("abort_no_done", 32'(done), 32'd0);
    end
    check_rf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
